counter_arbiter: RTL and testbench

- Shares one loadable up-counter (ports in/out/reset/load/inc/enable) among NUM_REQ requesters.
- Each requester asks for INC, LOAD, CLEAR or READ. The block arbitrates round-robin, drives the counter's control strobes for exactly one cycle, captures the result and returns it with a one-cycle ack.
- Sits between client logic and the counter instance; it is the only driver of the counter's control inputs.

---
 rtl/counter_arb_pkg.sv | 29 ++
 rtl/counter_arbiter_rr_arbiter.sv | 35 +++
 rtl/counter_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_counter_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_arb_pkg.sv
// Shared opcode and FSM encodings for the counter arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package counter_arb_pkg;

    // Width of one requester's opcode field inside the packed op bus.
    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_INC   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_ACK     = 2'b11
    } state_e;

    // Round-robin successor of a requester index.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after the pointer, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    logic w_found;

    // Scan positions ptr, ptr+1, ... (mod NUM_REQ); the first requester seen wins.
    always_comb begin
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_req[j] && (((int'(i_ptr) + k) % NUM_REQ) == j)) begin
                    w_found  = 1'b1;
                    o_gnt[j] = 1'b1;
                    o_idx    = PTR_W'(j);
                end
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/counter_arbiter.sv
// Arbitrates INC/LOAD/CLEAR/READ from NUM_REQ clients onto one shared up-counter.
// Latency: req seen in IDLE -> gnt next cycle -> ack + rdata three cycles after req; 4 cycles per op.
// Backpressure: req is held until ack; losers simply wait. COUNTER_ARB_LOCK_EN adds lock/LOCK_MAX.
`timescale 1ns/1ps
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 4
`ifdef COUNTER_ARB_LOCK_EN
    ,
    parameter int LOCK_MAX = 3
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [OP_W*NUM_REQ-1:0]  op,
    input  logic [WIDTH*NUM_REQ-1:0] wdata,
`ifdef COUNTER_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         rdata,
    output logic                     busy,
    output logic [WIDTH-1:0]         ctr_in,
    output logic                     ctr_load,
    output logic                     ctr_inc,
    output logic                     ctr_reset,
    output logic                     ctr_enable,
    input  logic [WIDTH-1:0]         ctr_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef COUNTER_ARB_LOCK_EN
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);
`endif

    // Registered state and outputs.
    state_e               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_idx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_busy;
    logic [WIDTH-1:0]     r_ctr_in;
    logic                 r_ctr_load;
    logic                 r_ctr_inc;
    logic                 r_ctr_reset;
    logic                 r_ctr_enable;
`ifdef COUNTER_ARB_LOCK_EN
    logic                 r_lock_vld;
    logic [LOCK_W-1:0]    r_lock_cnt;
`endif

    // Next-state values.
    state_e               w_state_nxt;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [PTR_W-1:0]     w_idx_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic [WIDTH-1:0]     w_rdata_nxt;
    logic                 w_busy_nxt;
    logic [WIDTH-1:0]     w_ctr_in_nxt;
    logic                 w_ctr_load_nxt;
    logic                 w_ctr_inc_nxt;
    logic                 w_ctr_reset_nxt;
    logic                 w_ctr_enable_nxt;
`ifdef COUNTER_ARB_LOCK_EN
    logic                 w_lock_vld_nxt;
    logic [LOCK_W-1:0]    w_lock_cnt_nxt;
    logic                 w_lock_own;
`endif

    // Arbitration and winner decode.
    logic [NUM_REQ-1:0]   w_rr_gnt;
    logic [PTR_W-1:0]     w_rr_idx;
    logic                 w_rr_any;
    logic [PTR_W-1:0]     w_sel_idx;
    logic                 w_sel_any;
    logic [NUM_REQ-1:0]   w_sel_gnt;
    op_e                  w_sel_op;
    logic [WIDTH-1:0]     w_sel_wdata;
    logic                 w_req_own;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // Look up the request (and lock) bit of the last owner.
    always_comb begin
        w_req_own = 1'b0;
`ifdef COUNTER_ARB_LOCK_EN
        w_lock_own = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_idx == PTR_W'(i)) begin
                w_req_own = req[i];
`ifdef COUNTER_ARB_LOCK_EN
                w_lock_own = lock[i];
`endif
            end
        end
    end

    // Choose the winner: a locked owner that re-requests beats round-robin until its budget runs out.
    always_comb begin
        w_sel_idx = w_rr_idx;
        w_sel_any = w_rr_any;
`ifdef COUNTER_ARB_LOCK_EN
        if (r_lock_vld && w_req_own && (r_lock_cnt < LOCK_W'(LOCK_MAX))) begin
            w_sel_idx = r_idx;
            w_sel_any = 1'b1;
        end
`endif
    end

    // Extract the winner's opcode, load data and one-hot grant.
    always_comb begin
        w_sel_op    = OP_READ;
        w_sel_wdata = '0;
        w_sel_gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_idx == PTR_W'(i)) begin
                w_sel_op     = op_e'(op[OP_W*i +: OP_W]);
                w_sel_wdata  = wdata[WIDTH*i +: WIDTH];
                w_sel_gnt[i] = 1'b1;
            end
        end
    end

    // FSM next state and registered-output next values; strobes are prepared in IDLE so they sit in ISSUE.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_idx_nxt        = r_idx;
        w_gnt_nxt        = r_gnt;
        w_ack_nxt        = '0;
        w_rdata_nxt      = r_rdata;
        w_ctr_in_nxt     = '0;
        w_ctr_load_nxt   = 1'b0;
        w_ctr_inc_nxt    = 1'b0;
        w_ctr_reset_nxt  = 1'b0;
        w_ctr_enable_nxt = 1'b0;
`ifdef COUNTER_ARB_LOCK_EN
        w_lock_vld_nxt   = r_lock_vld;
        w_lock_cnt_nxt   = r_lock_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef COUNTER_ARB_LOCK_EN
                // A lock only carries into the IDLE right after ACK.
                w_lock_vld_nxt = 1'b0;
`endif
                if (w_sel_any) begin
                    w_state_nxt      = ST_ISSUE;
                    w_idx_nxt        = w_sel_idx;
                    w_gnt_nxt        = w_sel_gnt;
                    w_ctr_enable_nxt = 1'b1;
                    case (w_sel_op)
                        OP_INC:   w_ctr_inc_nxt   = 1'b1;
                        OP_LOAD: begin
                            w_ctr_load_nxt = 1'b1;
                            w_ctr_in_nxt   = w_sel_wdata;
                        end
                        OP_CLEAR: w_ctr_reset_nxt = 1'b1;
                        OP_READ:  w_ctr_enable_nxt = 1'b1;
                        default:  w_ctr_enable_nxt = 1'b1;
                    endcase
`ifdef COUNTER_ARB_LOCK_EN
                    // Count consecutive grants to the same owner; a new owner restarts at one.
                    if ((w_sel_idx == r_idx) && (r_lock_cnt < LOCK_W'(LOCK_MAX)))
                        w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
                    else if (w_sel_idx != r_idx)
                        w_lock_cnt_nxt = LOCK_W'(1);
`endif
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_ACK;
                w_rdata_nxt = ctr_out;
                w_ack_nxt   = r_gnt;
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_ptr_nxt   = PTR_W'(rr_next(int'(r_idx), NUM_REQ));
`ifdef COUNTER_ARB_LOCK_EN
                w_lock_vld_nxt = w_lock_own;
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers; reset drops everything immediately, abandoning any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_gnt        <= '0;
            r_ack        <= '0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_ctr_in     <= '0;
            r_ctr_load   <= 1'b0;
            r_ctr_inc    <= 1'b0;
            r_ctr_reset  <= 1'b0;
            r_ctr_enable <= 1'b0;
`ifdef COUNTER_ARB_LOCK_EN
            r_lock_vld   <= 1'b0;
            r_lock_cnt   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_idx        <= w_idx_nxt;
            r_gnt        <= w_gnt_nxt;
            r_ack        <= w_ack_nxt;
            r_rdata      <= w_rdata_nxt;
            r_busy       <= w_busy_nxt;
            r_ctr_in     <= w_ctr_in_nxt;
            r_ctr_load   <= w_ctr_load_nxt;
            r_ctr_inc    <= w_ctr_inc_nxt;
            r_ctr_reset  <= w_ctr_reset_nxt;
            r_ctr_enable <= w_ctr_enable_nxt;
`ifdef COUNTER_ARB_LOCK_EN
            r_lock_vld   <= w_lock_vld_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
`endif
        end
    end

    assign gnt        = r_gnt;
    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign busy       = r_busy;
    assign ctr_in     = r_ctr_in;
    assign ctr_load   = r_ctr_load;
    assign ctr_inc    = r_ctr_inc;
    assign ctr_reset  = r_ctr_reset;
    assign ctr_enable = r_ctr_enable;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural shared counter attached.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic [W*N-1:0] wdata;
`ifdef COUNTER_ARB_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   rdata;
    logic           busy;
    logic [W-1:0]   ctr_in;
    logic           ctr_load;
    logic           ctr_inc;
    logic           ctr_reset;
    logic           ctr_enable;
    logic [W-1:0]   ctr_out;
    logic [W-1:0]   ctr_val = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_arbiter u_dut (
        .clk        (clk),
        .reset      (rst_n),
        .req        (req),
        .op         (op),
        .wdata      (wdata),
`ifdef COUNTER_ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt        (gnt),
        .ack        (ack),
        .rdata      (rdata),
        .busy       (busy),
        .ctr_in     (ctr_in),
        .ctr_load   (ctr_load),
        .ctr_inc    (ctr_inc),
        .ctr_reset  (ctr_reset),
        .ctr_enable (ctr_enable),
        .ctr_out    (ctr_out)
    );

    // Behavioural shared counter (not reset by the arbiter's reset).
    always @(posedge clk) begin
        if (ctr_enable) begin
            if (ctr_reset)     ctr_val <= '0;
            else if (ctr_load) ctr_val <= ctr_in;
            else if (ctr_inc)  ctr_val <= ctr_val + 1'b1;
        end
    end
    assign ctr_out = ctr_val;

    // Strobe exclusivity on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ($countones({ctr_load, ctr_inc, ctr_reset}) > 1) begin
                errors++;
                $display("FAIL strobe_onehot load=%b inc=%b clr=%b", ctr_load, ctr_inc, ctr_reset);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation for requester idx; returns observations, no checking here.
    task automatic run_op(input int idx, input logic [1:0] opc, input logic [W-1:0] d,
                          output logic [W-1:0] rd, output int lat,
                          output int n_load, output int n_inc, output int n_clr);
        rd = 'x; lat = -1; n_load = 0; n_inc = 0; n_clr = 0;
        req[idx] = 1'b1;
        op[2*idx +: 2] = opc;
        wdata[W*idx +: W] = d;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_load += int'(ctr_load);
            n_inc  += int'(ctr_inc);
            n_clr  += int'(ctr_reset);
            if (ack[idx]) begin
                lat = c;
                rd = rdata;
                break;
            end
        end
        req[idx] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; op = '0; wdata = '0;
`ifdef COUNTER_ARB_LOCK_EN
        lock = '0;
`endif
        tick(); tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", ack); end
        checks++; if (rdata !== 4'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if ({ctr_in, ctr_load, ctr_inc, ctr_reset, ctr_enable} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctr got %b exp 00000000", {ctr_in, ctr_load, ctr_inc, ctr_reset, ctr_enable});
        end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_single_load();
        req = 4'b0001; op[1:0] = 2'b01; wdata[3:0] = 4'b0101;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL load_gnt got %b exp 0001", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", busy); end
        checks++;
        if ({ctr_enable, ctr_load, ctr_inc, ctr_reset, ctr_in} !== 8'b1100_0101) begin
            errors++;
            $display("FAIL load_issue got %b exp 11000101", {ctr_enable, ctr_load, ctr_inc, ctr_reset, ctr_in});
        end
        // Changes after grant must be ignored.
        op[1:0] = 2'b10; wdata[3:0] = 4'b1010;
        tick();
        checks++;
        if ({ctr_enable, ctr_load, ctr_inc, ctr_reset} !== 4'b0000) begin
            errors++;
            $display("FAIL load_capture_strobes got %b exp 0000", {ctr_enable, ctr_load, ctr_inc, ctr_reset});
        end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL load_early_ack got %b exp 0000", ack); end
        tick();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL load_ack got %b exp 0001", ack); end
        checks++; if (rdata !== 4'b0101) begin errors++; $display("FAIL load_rdata got %b exp 0101", rdata); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL load_gnt_at_ack got %b exp 0001", gnt); end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, ack, busy} !== 9'd0) begin
            errors++;
            $display("FAIL load_release got gnt=%b ack=%b busy=%b exp 0", gnt, ack, busy);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] rd;
        int lat, nl, ni, nc;
        run_op(1, 2'b01, 4'b1111, rd, lat, nl, ni, nc);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wrap_load_latency got %0d exp 3", lat); end
        checks++; if (rd !== 4'b1111) begin errors++; $display("FAIL wrap_load_rdata got %b exp 1111", rd); end
        run_op(1, 2'b00, 4'b0000, rd, lat, nl, ni, nc);
        checks++; if (rd !== 4'b0000) begin errors++; $display("FAIL wrap_inc_rdata got %b exp 0000", rd); end
        checks++; if (ni !== 1) begin errors++; $display("FAIL wrap_inc_pulses got %0d exp 1", ni); end
        checks++; if (nl + nc !== 0) begin errors++; $display("FAIL wrap_inc_other_strobes got %0d exp 0", nl + nc); end
    endtask

    task automatic test_clear_read();
        logic [W-1:0] rd;
        int lat, nl, ni, nc;
        run_op(2, 2'b01, 4'b1000, rd, lat, nl, ni, nc);
        checks++; if (rd !== 4'b1000) begin errors++; $display("FAIL cr_load_rdata got %b exp 1000", rd); end
        run_op(2, 2'b10, 4'b0110, rd, lat, nl, ni, nc);
        checks++; if (rd !== 4'b0000) begin errors++; $display("FAIL clear_rdata got %b exp 0000", rd); end
        checks++; if (nc !== 1) begin errors++; $display("FAIL clear_pulses got %0d exp 1", nc); end
        run_op(2, 2'b11, 4'b0110, rd, lat, nl, ni, nc);
        checks++; if (rd !== 4'b0000) begin errors++; $display("FAIL read_rdata got %b exp 0000", rd); end
        checks++; if (nl + ni + nc !== 0) begin errors++; $display("FAIL read_strobes got %0d exp 0", nl + ni + nc); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d exp 3", lat); end
    endtask

    task automatic test_dropped_req();
        req[3] = 1'b1; op[7:6] = 2'b00; wdata[15:12] = 4'h0;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL drop_gnt got %b exp 1000", gnt); end
        req[3] = 1'b0;
        tick(); tick();
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL drop_ack got %b exp 1000", ack); end
        checks++; if (rdata !== 4'b0001) begin errors++; $display("FAIL drop_rdata got %b exp 0001", rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] order [5];
        logic [N-1:0] prev;
        logic [N-1:0] exp_order [5];
        int n;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        op = 8'hFF; req = 4'b1111;
        n = 0; prev = '0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (gnt !== 4'b0000 && gnt !== prev) begin
                order[n] = gnt;
                n++;
            end
            prev = gnt;
        end
        req = '0;
        repeat (4) tick();
        checks++; if (n !== 5) begin errors++; $display("FAIL rr_grant_count got %0d exp 5", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] !== exp_order[i]) begin
                errors++;
                $display("FAIL rr_order[%0d] got %b exp %b", i, order[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int seen_ack;
        op = 8'hFF; req = 4'b0101;
        tick();
        // Pointer sits at 1 after the previous grant to 0, so 2 wins.
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_pre_gnt got %b exp 0100", gnt); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, rdata, busy, ctr_in, ctr_load, ctr_inc, ctr_reset, ctr_enable} !== 21'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got gnt=%b ack=%b busy=%b en=%b", gnt, ack, busy, ctr_enable);
        end
        seen_ack = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (ack !== 4'b0000) seen_ack++;
        end
        rst_n = 1'b1;
        tick();
        if (ack !== 4'b0000) seen_ack++;
        checks++; if (seen_ack !== 0) begin errors++; $display("FAIL mid_no_ack got %0d exp 0", seen_ack); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %b exp 0001", gnt); end
        tick(); tick();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL mid_ack got %b exp 0001", ack); end
        req = '0;
        tick(); tick();
    endtask

`ifdef COUNTER_ARB_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] order [4];
        logic [N-1:0] prev;
        logic [N-1:0] exp_order [4];
        int n;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0001;
        exp_order[2] = 4'b0001; exp_order[3] = 4'b0010;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        op = 8'hFF; lock = 4'b0001; req = 4'b0011;
        n = 0; prev = '0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (gnt !== 4'b0000 && gnt !== prev) begin
                order[n] = gnt;
                n++;
            end
            prev = gnt;
        end
        req = '0; lock = '0;
        repeat (4) tick();
        checks++; if (n !== 4) begin errors++; $display("FAIL lock_grant_count got %0d exp 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] !== exp_order[i]) begin
                errors++;
                $display("FAIL lock_order[%0d] got %b exp %b", i, order[i], exp_order[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_load();
        test_wrap();
        test_clear_read();
        test_dropped_req();
        test_back_to_back();
        test_reset_mid_op();
`ifdef COUNTER_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
